// File: rtl/dec_display_arbiter.sv
// dec_display_arbiter
//   Round-robin arbiter that time-shares one 4-bit value path into the
//   two-digit 7-segment decoder among four requesters. A winner gets a
//   one-cycle ack, its value is latched onto bin_o, and it is held for
//   DWELL_CYCLES cycles before the next arbitration.
//
// Ports
//   clk_i    system clock, rising edge
//   rst_i    synchronous active-high reset
//   req_i    [3:0]  per-requester request, held until its ack
//   val_i    [15:0] requester i owns val_i[4i+3:4i]
//   ack_o    [3:0]  one-cycle grant pulse (one-hot or zero)
//   bin_o    [3:0]  registered decoder input
//   owner_o  [1:0]  requester whose value is on bin_o
//   busy_o          high in GRANT and SHOW
//   blank_o         high until the first value has been latched
module dec_display_arbiter #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  req_i,
  input  logic [15:0] val_i,
  output logic [3:0]  ack_o,
  output logic [3:0]  bin_o,
  output logic [1:0]  owner_o,
  output logic        busy_o,
  output logic        blank_o
);

  typedef enum logic [1:0] {IDLE, GRANT, SHOW} state_t;

  state_t           state_q, state_d;
  logic [1:0]       winner_q, winner_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bin_q, bin_d;
  logic [1:0]       owner_q, owner_d;
  logic             blank_q, blank_d;

  // Round-robin search starting at rr_ptr_q. Scanning from the far end
  // down lets the nearest active requester overwrite earlier candidates.
  logic       arb_hit;
  logic [1:0] arb_idx;
  logic [1:0] cand;

  always_comb begin
    arb_hit = 1'b0;
    arb_idx = rr_ptr_q;
    cand    = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr_q + 2'(k);
      if (req_i[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    owner_d  = owner_q;
    blank_d  = blank_q;
    unique case (state_q)
      IDLE: begin
        if (arb_hit) begin
          state_d  = GRANT;
          winner_d = arb_idx;
          rr_ptr_d = arb_idx + 2'd1;
        end
      end
      GRANT: begin
        // val is sampled at the end of the ack cycle
        state_d = SHOW;
        bin_d   = val_i[4*winner_q +: 4];
        owner_d = winner_q;
        cnt_d   = CNT_W'(DWELL_CYCLES - 1);
        blank_d = 1'b0;
      end
      SHOW: begin
        if (cnt_q == '0) begin
          if (arb_hit) begin
            state_d  = GRANT;
            winner_d = arb_idx;
            rr_ptr_d = arb_idx + 2'd1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      winner_q <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      bin_q    <= '0;
      owner_q  <= '0;
      blank_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      owner_q  <= owner_d;
      blank_q  <= blank_d;
    end
  end

  // Moore outputs only: nothing combinational from req_i reaches them.
  assign ack_o   = (state_q == GRANT) ? (4'b0001 << winner_q) : 4'b0000;
  assign busy_o  = (state_q != IDLE);
  assign bin_o   = bin_q;
  assign owner_o = owner_q;
  assign blank_o = blank_q;

endmodule

// File: doc/dec_display_arbiter.md
# dec_display_arbiter

Round-robin arbiter that shares the single 4-bit binary-to-two-digit 7-segment decoder among four requesters. It grants one requester at a time with a req/ack handshake and latches that requester's 4-bit value onto the decoder input. It holds the value for a fixed dwell time before serving the next requester. It sits between the lab's value sources (switches, counters, FSM status) and the decoder that drives the two HEX displays.

## Interface
- DWELL_CYCLES, 50_000_000: number of clk cycles each granted value is displayed; legal range 1 to 2^CNT_W.
- CNT_W, 26: width of the dwell counter.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester i; held high until ack[i].
- val  input  16  packed values; requester i owns val[4i+3:4i]; stable while req[i] is high.
- ack  output  4  one-cycle grant pulse, at most one bit set.
- bin  output  4  registered value driven to the decoder input.
- owner  output  2  index of the requester whose value is on bin.
- busy  output  1  high in GRANT and SHOW.
- blank  output  1  high until the first grant; the top level forces both HEX outputs to 8'hFF while it is set.

## Operation
- States:
  - IDLE: no active dwell.
  - GRANT: exactly one cycle; ack[winner] is high.
  - SHOW: dwell in progress.
- Arbitration:
  - Combinational over req, starting at rr_ptr and wrapping 3→0.
  - Evaluated in IDLE, and in SHOW only on the cycle the counter equals 0.
  - rr_ptr resets to 0, so requester 0 has the highest initial priority.
  - After a grant to i, rr_ptr becomes (i+1) mod 4.
- IDLE → GRANT when any req bit is high. The winner is registered in the same edge. IDLE with no req stays in IDLE.
- GRANT → SHOW unconditionally. On that edge:
  - bin ← val slice of the winner
  - owner ← winner
  - counter ← DWELL_CYCLES-1
  - blank ← 0
- SHOW: the counter decrements every cycle. When the counter equals 0:
  - any req high → GRANT (new winner registered);
  - otherwise → IDLE.
- In IDLE, bin, owner and blank keep their last values. The display is not re-blanked.
- A requester holding req high after its ack is treated as a new request. It is served again only after the other active requesters, per rr_ptr.
- A req that drops before ack is lost. No grant is issued for it unless it is still high at the arbitration cycle.
- val values 0–15 all pass through unchanged. Range checking belongs to the decoder.
- Reset values: state IDLE, ack 0, bin 0, owner 0, busy 0, blank 1, rr_ptr 0, counter 0.
- Reset asserted mid-GRANT suppresses the following latch; the ack already driven that cycle is the only ack. Reset asserted mid-SHOW aborts the dwell and re-blanks.

## Timing
- Latency: req[i] high at edge k with state IDLE → ack[i] high during cycle k+1 → bin valid from edge k+2.
- Dwell:
  - bin is stable for exactly DWELL_CYCLES cycles of SHOW.
  - Back-to-back grants give a grant period of DWELL_CYCLES+1 cycles (SHOW plus one GRANT cycle).
  - The outgoing value stays on bin through the GRANT cycle, so there is no blank gap.
- ack is a Moore output: decoded from state==GRANT and the registered winner.
- val is sampled at the end of the ack cycle. Requesters must hold val through that cycle.
- Simultaneous requests resolve in a single cycle. No combinational path exists from req to ack or bin.
- With DWELL_CYCLES=1, SHOW lasts one cycle; GRANT→SHOW→GRANT alternates under continuous load.

## Test plan
All scenarios use DWELL_CYCLES=4.
- Reset: hold rst 3 cycles with req=4'b1111 → ack=0, bin=0, owner=0, busy=0, blank=1 throughout; the first ack appears 2 cycles after rst release, on ack[0].
- Single request: req=4'b0100, val[11:8]=4'd13 → ack=4'b0100 for exactly 1 cycle; next edge bin=13, owner=2, blank=0; busy high 5 cycles, then IDLE with bin still 13.
- Round-robin rotation: req=4'b1111 held continuously, val slices 1,2,3,4 → ack order 0,1,2,3,0 with 5-cycle spacing; bin sequence 1,2,3,4,1.
- Fairness after wrap: serve requester 3, then raise req=4'b1001 → next ack[0], then ack[3]; never ack[3] twice in a row while req[0] is pending.
- Late arrival: req[1] rises during the 2nd SHOW cycle of owner 0 → ack[1] in the cycle after the counter reaches 0; owner 0's value is displayed the full 4 cycles.
- Reset mid-SHOW: assert rst on the 2nd SHOW cycle → next edge busy=0, blank=1, bin=0, rr_ptr=0; the next grant goes to the lowest-indexed active req.
